// File: rtl/bcd_adjust_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_adjust_seq_if
// Purpose  : Request/response handshake bundle for the decimal/ASCII adjust unit.
// Revision : 1.0
// ============================================================================
interface bcd_adjust_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] ax_in;
    logic [7:0]  imm8;
    logic        cf_in;
    logic        af_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ax_out;
    logic        cf_out;
    logic        af_out;
    logic        sf_out;
    logic        zf_out;
    logic        pf_out;
    logic        div_err;
    logic [5:0]  set_eflags;

    modport master (
        output in_valid, op, ax_in, imm8, cf_in, af_in, out_ready,
        input  in_ready, out_valid, ax_out, cf_out, af_out, sf_out, zf_out,
               pf_out, div_err, set_eflags
    );

    modport slave (
        input  in_valid, op, ax_in, imm8, cf_in, af_in, out_ready,
        output in_ready, out_valid, ax_out, cf_out, af_out, sf_out, zf_out,
               pf_out, div_err, set_eflags
    );
endinterface
`default_nettype wire

// File: rtl/bcd_adjust_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_adjust_seq
// Purpose  : DAS (single cycle), AAM (restoring divide) and AAD (shift-add).
// Revision : 1.0
// ============================================================================
module bcd_adjust_seq #(
    parameter int ITERS = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        flush,
    bcd_adjust_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_DAS   = 2'b00;
    localparam logic [1:0] OP_AAM   = 2'b01;
    localparam logic [1:0] OP_AAD   = 2'b10;
    localparam logic [5:0] MASK_DAS = 6'b011111;
    localparam logic [5:0] MASK_ASC = 6'b011010;
    localparam int         CNT_W    = $clog2(ITERS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_aam_q, is_aam_d;
    // a: AAM dividend/quotient or AAD multiplier; b: divisor or multiplicand;
    // r: AAM partial remainder or AAD accumulator (low 8 bits).
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [8:0]       r_q, r_d;
    logic [15:0]      ax_out_q, ax_out_d;
    logic             cf_out_q, cf_out_d, af_out_q, af_out_d;
    logic             sf_out_q, sf_out_d, zf_out_q, zf_out_d, pf_out_q, pf_out_d;
    logic             div_err_q, div_err_d;
    logic [5:0]       set_eflags_q, set_eflags_d;

    function automatic logic [2:0] szp(input logic [7:0] v);
        return {v[7], (v == 8'h00), ~^v};
    endfunction

    logic [7:0] al_in, ah_in;
    assign al_in = bus.ax_in[7:0];
    assign ah_in = bus.ax_in[15:8];

    logic [7:0] das_al1, das_al;
    logic       das_borrow, das_cf1, das_cf, das_af;

    always_comb begin
        das_al1    = al_in;
        das_borrow = 1'b0;
        das_cf1    = 1'b0;
        das_af     = 1'b0;
        if (al_in[3:0] > 4'd9 || bus.af_in) begin
            {das_borrow, das_al1} = {1'b0, al_in} - 9'd6;
            das_cf1 = bus.cf_in | das_borrow;
            das_af  = 1'b1;
        end
        das_al = das_al1;
        das_cf = das_cf1;
        // The high-nibble test looks at the original AL and CF, not the low-adjusted ones.
        if (al_in > 8'h99 || bus.cf_in) begin
            das_al = das_al1 - 8'h60;
            das_cf = 1'b1;
        end
    end

    logic [8:0] rem_sh, div_rem;
    logic       div_ge;
    logic [7:0] div_quo, mul_acc, fin_al;

    always_comb begin
        rem_sh  = {r_q[7:0], a_q[7]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        div_rem = div_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        div_quo = {a_q[6:0], div_ge};
        mul_acc = a_q[0] ? (r_q[7:0] + b_q) : r_q[7:0];
        fin_al  = is_aam_q ? div_rem[7:0] : mul_acc;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_aam_d     = is_aam_q;
        a_d          = a_q;
        b_d          = b_q;
        r_d          = r_q;
        ax_out_d     = ax_out_q;
        cf_out_d     = cf_out_q;
        af_out_d     = af_out_q;
        sf_out_d     = sf_out_q;
        zf_out_d     = zf_out_q;
        pf_out_d     = pf_out_q;
        div_err_d    = div_err_q;
        set_eflags_d = set_eflags_q;
        case (state_q)
            S_IDLE: begin
                if (!flush && bus.in_valid) begin
                    state_d      = S_DONE;
                    ax_out_d     = bus.ax_in;
                    cf_out_d     = bus.cf_in;
                    af_out_d     = bus.af_in;
                    {sf_out_d, zf_out_d, pf_out_d} = szp(al_in);
                    div_err_d    = 1'b0;
                    set_eflags_d = '0;
                    case (bus.op)
                        OP_DAS: begin
                            ax_out_d     = {ah_in, das_al};
                            cf_out_d     = das_cf;
                            af_out_d     = das_af;
                            {sf_out_d, zf_out_d, pf_out_d} = szp(das_al);
                            set_eflags_d = MASK_DAS;
                        end
                        OP_AAM: begin
                            if (bus.imm8 == 8'h00) begin
                                div_err_d = 1'b1;
                            end else begin
                                state_d      = S_ITER;
                                is_aam_d     = 1'b1;
                                a_d          = al_in;
                                b_d          = bus.imm8;
                                r_d          = '0;
                                cnt_d        = '0;
                                set_eflags_d = MASK_ASC;
                            end
                        end
                        OP_AAD: begin
                            state_d      = S_ITER;
                            is_aam_d     = 1'b0;
                            a_d          = ah_in;
                            b_d          = bus.imm8;
                            r_d          = {1'b0, al_in};
                            cnt_d        = '0;
                            set_eflags_d = MASK_ASC;
                        end
                        default: ;
                    endcase
                end
            end
            S_ITER: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_aam_q) begin
                        a_d = div_quo;
                        r_d = div_rem;
                    end else begin
                        a_d = {1'b0, a_q[7:1]};
                        b_d = {b_q[6:0], 1'b0};
                        r_d = {1'b0, mul_acc};
                    end
                    if (cnt_q == LAST) begin
                        state_d  = S_DONE;
                        ax_out_d = is_aam_q ? {div_quo, fin_al} : {8'h00, fin_al};
                        {sf_out_d, zf_out_d, pf_out_d} = szp(fin_al);
                    end
                end
            end
            S_DONE: begin
                if (flush || bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_aam_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            ax_out_q     <= '0;
            cf_out_q     <= 1'b0;
            af_out_q     <= 1'b0;
            sf_out_q     <= 1'b0;
            zf_out_q     <= 1'b0;
            pf_out_q     <= 1'b0;
            div_err_q    <= 1'b0;
            set_eflags_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_aam_q     <= is_aam_d;
            a_q          <= a_d;
            b_q          <= b_d;
            r_q          <= r_d;
            ax_out_q     <= ax_out_d;
            cf_out_q     <= cf_out_d;
            af_out_q     <= af_out_d;
            sf_out_q     <= sf_out_d;
            zf_out_q     <= zf_out_d;
            pf_out_q     <= pf_out_d;
            div_err_q    <= div_err_d;
            set_eflags_q <= set_eflags_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.ax_out     = ax_out_q;
    assign bus.cf_out     = cf_out_q;
    assign bus.af_out     = af_out_q;
    assign bus.sf_out     = sf_out_q;
    assign bus.zf_out     = zf_out_q;
    assign bus.pf_out     = pf_out_q;
    assign bus.div_err    = div_err_q;
    assign bus.set_eflags = set_eflags_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_adjust_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_adjust_seq
// Purpose  : Vector table plus scoreboard bench for bcd_adjust_seq.
// Revision : 1.0
// ============================================================================
module tb_bcd_adjust_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bcd_adjust_seq_if bus ();

    bcd_adjust_seq #(.ITERS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // e_edges counts clock edges from the accept edge (inclusive) to out_valid.
    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] ax;
        logic [7:0]  imm;
        logic        cf, af;
        logic [15:0] e_ax;
        logic        e_cf, e_af, e_sf, e_zf, e_pf, e_de;
        logic [5:0]  e_set;
        int          e_edges;
        bit          chk_szp;
    } vec_t;

    vec_t vecs[15];
    vec_t sb[$];

    function automatic vec_t mk(string nm, logic [1:0] op, logic [15:0] ax, logic [7:0] imm,
                                logic cf, logic af, logic [15:0] e_ax, logic e_cf, logic e_af,
                                logic e_sf, logic e_zf, logic e_pf, logic e_de, logic [5:0] e_set,
                                int e_edges, bit chk_szp);
        vec_t v;
        v.name = nm; v.op = op; v.ax = ax; v.imm = imm; v.cf = cf; v.af = af;
        v.e_ax = e_ax; v.e_cf = e_cf; v.e_af = e_af; v.e_sf = e_sf; v.e_zf = e_zf;
        v.e_pf = e_pf; v.e_de = e_de; v.e_set = e_set; v.e_edges = e_edges; v.chk_szp = chk_szp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic compare_out();
        vec_t v;
        v = sb.pop_front();
        check($sformatf("%s ax_out", v.name), 32'(bus.ax_out), 32'(v.e_ax));
        check($sformatf("%s cf", v.name), 32'(bus.cf_out), 32'(v.e_cf));
        check($sformatf("%s af", v.name), 32'(bus.af_out), 32'(v.e_af));
        check($sformatf("%s div_err", v.name), 32'(bus.div_err), 32'(v.e_de));
        check($sformatf("%s set_eflags", v.name), 32'(bus.set_eflags), 32'(v.e_set));
        if (v.chk_szp) begin
            check($sformatf("%s sf", v.name), 32'(bus.sf_out), 32'(v.e_sf));
            check($sformatf("%s zf", v.name), 32'(bus.zf_out), 32'(v.e_zf));
            check($sformatf("%s pf", v.name), 32'(bus.pf_out), 32'(v.e_pf));
        end
    endtask

    task automatic accept(input logic [1:0] op, input logic [15:0] ax, input logic [7:0] imm,
                          input logic cf, input logic af);
        bus.op = op; bus.ax_in = ax; bus.imm8 = imm; bus.cf_in = cf; bus.af_in = af;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int w;
        int edges;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        check($sformatf("%s in_ready before", v.name), 32'(bus.in_ready), 32'(1));
        accept(v.op, v.ax, v.imm, v.cf, v.af);
        sb.push_back(v);
        edges = 1;
        while (!bus.out_valid && edges < 30) begin @(posedge clk); #1; edges++; end
        check($sformatf("%s latency", v.name), 32'(edges), 32'(v.e_edges));
        compare_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("%s drained", v.name), 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.ax_in = '0; bus.imm8 = '0;
        bus.cf_in = 1'b0; bus.af_in = 1'b0; bus.out_ready = 1'b0;

        //          name        op     ax        imm    cf af  e_ax      cf af sf zf pf de set        edges szp
        vecs[0]  = mk("das_ee",  2'b00, 16'h00EE, 8'h0A, 1, 1, 16'h0088, 1, 1, 1, 0, 1, 0, 6'b011111, 1, 1);
        vecs[1]  = mk("das_12",  2'b00, 16'h0012, 8'h0A, 0, 0, 16'h0012, 0, 0, 0, 0, 1, 0, 6'b011111, 1, 1);
        vecs[2]  = mk("das_9a",  2'b00, 16'h349A, 8'h0A, 0, 0, 16'h3434, 1, 1, 0, 0, 0, 0, 6'b011111, 1, 1);
        vecs[3]  = mk("das_06",  2'b00, 16'h0006, 8'h0A, 0, 1, 16'h0000, 0, 1, 0, 1, 1, 0, 6'b011111, 1, 1);
        vecs[4]  = mk("das_brw", 2'b00, 16'h0003, 8'h0A, 0, 1, 16'h00FD, 1, 1, 1, 0, 0, 0, 6'b011111, 1, 1);
        vecs[5]  = mk("aam_41",  2'b01, 16'h0041, 8'h0A, 1, 0, 16'h0605, 1, 0, 0, 0, 1, 0, 6'b011010, 9, 1);
        vecs[6]  = mk("aad_74",  2'b10, 16'h0704, 8'h0A, 0, 1, 16'h004A, 0, 1, 0, 0, 0, 0, 6'b011010, 9, 1);
        vecs[7]  = mk("aad_0",   2'b10, 16'h0000, 8'h0A, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 6'b011010, 9, 1);
        vecs[8]  = mk("aam_de",  2'b01, 16'h1234, 8'h00, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 0);
        vecs[9]  = mk("aam_ff",  2'b01, 16'h00FF, 8'h10, 0, 0, 16'h0F0F, 0, 0, 0, 0, 1, 0, 6'b011010, 9, 1);
        vecs[10] = mk("aam_big", 2'b01, 16'hAB05, 8'hFF, 0, 1, 16'h0005, 0, 1, 0, 0, 1, 0, 6'b011010, 9, 1);
        vecs[11] = mk("aad_wrap",2'b10, 16'hFF01, 8'hFF, 1, 1, 16'h0002, 1, 1, 0, 0, 0, 0, 6'b011010, 9, 1);
        vecs[12] = mk("op_rsv",  2'b11, 16'hBEEF, 8'h0A, 1, 1, 16'hBEEF, 1, 1, 0, 0, 0, 0, 6'b000000, 1, 0);
        vecs[13] = mk("aam_63",  2'b01, 16'h0063, 8'h0A, 0, 0, 16'h0909, 0, 0, 0, 0, 1, 0, 6'b011010, 9, 1);
        vecs[14] = mk("aad_95",  2'b10, 16'h0905, 8'h0A, 0, 0, 16'h005F, 0, 0, 0, 0, 1, 0, 6'b011010, 9, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset ax_out", 32'(bus.ax_out), 32'(0));
        check("reset valid/ready", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));
        check("reset flags", 32'({bus.cf_out, bus.af_out, bus.sf_out, bus.zf_out, bus.pf_out,
                                  bus.div_err, bus.set_eflags}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_op(vecs[i]);

        // Flush presented together with a request: nothing may be accepted.
        bus.op = 2'b00; bus.ax_in = 16'h0012; bus.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));

        // Flush on the third ITER cycle of AAM.
        accept(2'b01, 16'h0063, 8'h0A, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_iter idle", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check("flush_iter no valid", 32'(seen_valid), 32'(0));
        run_op(vecs[13]);

        // Hold a DAS result in DONE with the consumer stalled.
        accept(2'b00, 16'h00EE, 8'h0A, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold %0d", i), 32'({bus.out_valid, bus.in_ready, bus.ax_out,
                                                bus.cf_out, bus.af_out}), 32'({2'b10, 16'h0088, 2'b11}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("hold drain", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));

        // Asynchronous reset in the middle of AAD.
        accept(2'b10, 16'h0704, 8'h0A, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid ax_out", 32'(bus.ax_out), 32'(0));
        check("rst_mid state", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
        check("rst_mid flags", 32'({bus.cf_out, bus.af_out, bus.sf_out, bus.zf_out, bus.pf_out,
                                    bus.div_err, bus.set_eflags}), 32'(0));
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(vecs[13]);

        check("scoreboard empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
